// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;
    localparam logic [5:0]  LAST_ITER  = 6'd31;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned 64-bit shift datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per i_step; i_load seeds the magnitudes.
module muldiv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_div,
    input  logic        i_step,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    logic        r_div;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [32:0] w_sum;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_sum     = {1'b0, r_hi} + {1'b0, r_m};
    assign w_mul_nxt = r_lo[0] ? {w_sum, r_lo[31:1]} : {1'b0, r_hi, r_lo[31:1]};
    assign w_shift   = {r_hi, r_lo[31]};
    assign w_ge      = (w_shift >= {1'b0, r_m});
    // Only used when w_ge, so the true difference is below r_m and fits 32 bits.
    assign w_diff    = w_shift[31:0] - r_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= 1'b0;
            r_m   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_hi  <= '0;
            r_m   <= i_div ? i_b : i_a;
            r_lo  <= i_div ? i_a : i_b;
        end else if (i_step) begin
            if (r_div) begin
                r_hi <= w_ge ? w_diff : w_shift[31:0];
                r_lo <= {r_lo[30:0], w_ge};
            end else begin
                {r_hi, r_lo} <= w_mul_nxt;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// MULT/MULTU/DIV/DIVU with architectural HI/LO: 32 iteration cycles plus a
// sign-fix cycle; busy in CALC/FIX, cancel aborts without touching HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] W,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    state_e      r_state;
    state_e      w_next;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_b_zero;
    logic [31:0] r_abs_a;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;

    logic        w_accept;
    logic        w_fix_wr;
    logic        w_mt_ok;
    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = op[1];
    assign w_abs_a  = (w_signed && A[31]) ? -A : A;
    assign w_abs_b  = (w_signed && B[31]) ? -B : B;

    muldiv_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_div  (w_is_div),
        .i_step (r_state == ST_CALC),
        .i_a    (w_abs_a),
        .i_b    (w_abs_b),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fix_wr = 1'b0;
        w_mt_ok  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    w_next   = ST_CALC;
                    w_accept = 1'b1;
                end else begin
                    w_mt_ok = 1'b1;
                end
            end
            ST_CALC: begin
                if (cancel)                  w_next = ST_IDLE;
                else if (r_cnt == LAST_ITER) w_next = ST_FIX;
            end
            ST_FIX: begin
                if (cancel) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next   = ST_DONE;
                    w_fix_wr = 1'b1;
                end
            end
            ST_DONE: begin
                w_next  = ST_IDLE;
                w_mt_ok = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Signed 0x80000000 / -1 needs no special case: the magnitude quotient
    // is 0x80000000 and the sign correction leaves it unchanged.
    assign w_prod_mag = {w_core_hi, w_core_lo};
    assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_res_lo = DIVZERO_LO;
                w_res_hi = r_neg_r ? -r_abs_a : r_abs_a;
            end else begin
                w_res_lo = r_neg_q ? -w_core_lo : w_core_lo;
                w_res_hi = r_neg_r ? -w_core_hi : w_core_hi;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_abs_a  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_busy <= (w_next == ST_CALC) || (w_next == ST_FIX);
            r_done <= w_fix_wr;
            r_dbz  <= w_fix_wr && r_is_div && r_b_zero;
            if (w_accept) begin
                r_cnt    <= '0;
                r_is_div <= w_is_div;
                r_neg_q  <= w_signed && (A[31] ^ B[31]);
                r_neg_r  <= w_signed && A[31];
                r_b_zero <= (B == '0);
                r_abs_a  <= w_abs_a;
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_fix_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_mt_ok) begin
                if (mthi) r_hi <= W;
                if (mtlo) r_lo <= W;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign HI          = r_hi;
    assign LO          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_by_zero queued at launch, compared on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cancel = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] W = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          k_start = 0;
    logic [31:0] hi_prev;
    logic [31:0] lo_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .cancel      (cancel),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .W           (W),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input op_e o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          q;
        int          r;
        e = '0;
        case (o)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {e.hi, e.lo} = p;
            end
            OP_MULTU: begin
                u = {32'h0, a} * {32'h0, b};
                {e.hi, e.lo} = u;
            end
            default: begin
                if (b == 32'h0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else if (o == OP_DIVU) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    q    = $signed(a) / $signed(b);
                    r    = $signed(a) % $signed(b);
                    e.lo = q;
                    e.hi = r;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("hi", HI, e.hi);
                check("lo", LO, e.lo);
                check("dbz", div_by_zero, e.dbz);
            end
        end
    end

    task automatic launch(input op_e o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        k_start = cyc;
        check("busy_on", busy, 1'b1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        if (seen) check("latency", cyc - k_start, 33);
    endtask

    task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        sb_q.push_back(e);
        launch(o, a, b);
        wait_done();
        @(posedge clk);
        #1;
        check("busy_off", busy, 1'b0);
    endtask

    initial begin
        op_e         o;
        logic [31:0] a;
        logic [31:0] b;

        #1 rst = 1'b1;
        #1;
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'h3,         '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0});
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h2,         '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        run_op(OP_DIVU,  32'h7,         32'h0,         '{32'h0000_0007, 32'hFFFF_FFFF, 1'b1});
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, '{32'h0000_0000, 32'h8000_0000, 1'b0});
        run_op(OP_DIV,   32'hFFFF_FF00, 32'h0,         '{32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1});

        for (int i = 0; i < 12; i++) begin
            o = op_e'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(16, 31);
            if (i == 5) b = 32'h0;
            run_op(o, a, b, model(o, a, b));
        end

        // HI/LO direct writes in IDLE
        @(negedge clk);
        W    = 32'h0000_1234;
        mthi = 1'b1;
        @(posedge clk);
        #1 mthi = 1'b0;
        check("mthi_idle", HI, 32'h0000_1234);
        @(negedge clk);
        W    = 32'h0000_5678;
        mtlo = 1'b1;
        @(posedge clk);
        #1 mtlo = 1'b0;
        check("mtlo_idle", LO, 32'h0000_5678);

        // mtlo and a second start while busy are both ignored
        sb_q.push_back(model(OP_MULTU, 32'd3, 32'd5));
        launch(OP_MULTU, 32'd3, 32'd5);
        lo_prev = LO;
        repeat (4) @(posedge clk);
        @(negedge clk);
        W    = 32'hDEAD_BEEF;
        mtlo = 1'b1;
        op   = OP_DIV;
        A    = 32'd100;
        B    = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        mtlo  = 1'b0;
        start = 1'b0;
        check("mtlo_busy", LO, lo_prev);
        wait_done();

        // start while in DONE is ignored
        @(negedge clk);
        op    = OP_MULT;
        A     = 32'd9;
        B     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_in_done", busy, 1'b0);

        // cancel at cycle 10: no done, HI/LO unchanged
        hi_prev = HI;
        lo_prev = LO;
        launch(OP_MULT, 32'h1234_5678, 32'h0000_0777);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_busy", busy, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hi", HI, hi_prev);
        check("cancel_lo", LO, lo_prev);

        // cancel together with start in IDLE
        @(negedge clk);
        op     = OP_DIVU;
        A      = 32'd50;
        B      = 32'd5;
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_start_idle", busy, 1'b0);
        repeat (40) @(posedge clk);

        // start wins over mthi in the same IDLE cycle
        hi_prev = HI;
        sb_q.push_back(model(OP_MULTU, 32'd2, 32'd3));
        @(negedge clk);
        op    = OP_MULTU;
        A     = 32'd2;
        B     = 32'd3;
        start = 1'b1;
        W     = 32'h0000_ABCD;
        mthi  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mthi    = 1'b0;
        k_start = cyc;
        check("start_mthi_busy", busy, 1'b1);
        check("start_mthi_hi", HI, hi_prev);
        wait_done();
        @(posedge clk);

        // reset mid-operation clears everything at once
        launch(OP_DIV, 32'hFFFF_0000, 32'd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_hi", HI, 32'h0);
        check("midrst_lo", LO, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        op    = OP_DIVU;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        sb_q.push_back('{32'd2, 32'd14, 1'b0});
        @(posedge clk);
        #1;
        start   = 1'b0;
        k_start = cyc;
        check("post_rst_start", busy, 1'b1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  launch operation; sampled on posedge.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  input  32  operand rs (multiplicand/dividend), from register-file read port A.
REQ-007 B  input  32  operand rt (multiplier/divisor), from register-file read port B.
REQ-008 cancel  input  1  abort in-flight operation (interrupt entry).
REQ-009 mthi, mtlo  input  1 each  direct write of HI/LO from W.
REQ-010 W  input  32  write data for mthi/mtlo.
REQ-011 busy  output  1  operation in flight; new start ignored.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 div_by_zero  output  1  pulsed with done when a DIV/DIVU had B==0.
REQ-014 HI, LO  output  32 each  architectural HI/LO registers.

Function
REQ-015 FSM states: IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after 32 iterations; FIX->DONE; DONE->IDLE.
REQ-016 On accepted start: latch op, |A|, |B| (absolute values for MULT/DIV; raw values for MULTU/DIVU), sign bits; clear 6-bit iteration counter.
REQ-017 CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter increments 0..31.
REQ-018 FIX: apply sign correction; write HI/LO on this edge.
REQ-019 Latency: start sampled at edge k -> HI/LO updated at edge k+33; done high in cycle after edge k+33; busy high in CALC and FIX only.
REQ-020 Multiply: {HI,LO} = full 64-bit product; signed result negated when sign(A)^sign(B).
REQ-021 Divide: LO = quotient, HI = remainder; quotient sign = sign(A)^sign(B); remainder sign = sign(A).
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 B==0 on DIV/DIVU: full latency kept; LO=0xFFFFFFFF, HI=A; div_by_zero pulsed with done; no trap raised.
REQ-024 start while busy or in DONE: ignored, no queuing.
REQ-025 mthi/mtlo in IDLE or DONE: register written from W at the edge; while busy: ignored.
REQ-026 start and mthi/mtlo in the same IDLE cycle: start taken, the mthi/mtlo write is dropped.
REQ-027 cancel in CALC or FIX: next state IDLE, HI/LO unchanged, no done pulse; cancel has priority over the FIX write; cancel in IDLE has no effect.
REQ-028 cancel and start in the same IDLE cycle: start ignored.
REQ-029 Outputs HI, LO, busy, done and div_by_zero are registered.

Reset
REQ-030 rst asserted: state=IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, counter=0, operand latches=0, immediately (asynchronous).
REQ-031 rst mid-operation: operation discarded, no done pulse; first start accepted on the first posedge after rst deasserts.

Structure
REQ-032 Shared package muldiv_pkg holds: op encodings, FSM state encoding, DIVZERO_LO constant (0xFFFFFFFF).
REQ-033 Sub-module muldiv_core: the 64-bit shift datapath and single-step add/subtract; the FSM, sign handling and HI/LO live in muldiv_unit.

Verification
REQ-034 MULT A=0xFFFFFFFE (-2), B=3 -> 33 cycles later done; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7, div_by_zero=1.
REQ-037 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 start MULT, cancel at cycle 10 -> busy falls next edge, no done, HI/LO keep prior values; second start during busy -> ignored.
REQ-039 mthi W=0x1234 in IDLE -> HI=0x1234; mtlo during busy -> LO unchanged; rst at cycle 20 -> all outputs 0.
